// File: rtl/async_synchro_pkg.sv
// Shared types and helpers for the asynchronous input resynchroniser.
// Pulse-source selection is encoded in 2 bits per channel.
package async_synchro_pkg;

  typedef logic [1:0] sync_mode_t;

  localparam sync_mode_t MODE_LEVEL = 2'b00;
  localparam sync_mode_t MODE_RISE  = 2'b01;
  localparam sync_mode_t MODE_FALL  = 2'b10;
  localparam sync_mode_t MODE_BOTH  = 2'b11;

  // True when an accepted change to new_level should raise a pulse under mode
  function automatic logic edge_selected(input sync_mode_t mode, input logic new_level);
    logic sel;
    sel = 1'b0;
    case (mode)
      MODE_RISE: sel = new_level;
      MODE_FALL: sel = ~new_level;
      MODE_BOTH: sel = 1'b1;
      default:   sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/synchro_filter_ch.sv
// One channel: flop-chain synchroniser, stability filter, level and edge pulse registers.
// A change is accepted only after FILTER_CYCLES consecutive synchronised samples disagree with level.
module synchro_filter_ch
  import async_synchro_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter logic        RESET_VAL_BIT = 1'b0,
  parameter sync_mode_t  MODE_CH       = MODE_RISE
) (
  input  logic aclk,
  input  logic arstn,
  input  logic din,
  output logic level,
  output logic pulse
);

  localparam int unsigned CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] chain;
  logic             s;
  logic [CNT_W-1:0] cnt;

  // Plain shift chain; stage 0 is the metastability-capturing flop
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      chain <= {SYNC_STAGES{RESET_VAL_BIT}};
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
    end
  end

  assign s = chain[SYNC_STAGES-1];

  // Any agreement with level restarts the stability count
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      level <= RESET_VAL_BIT;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= s;
        cnt   <= '0;
        pulse <= edge_selected(MODE_CH, s);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/async_input_synchro.sv
// Multi-channel resynchroniser for asynchronous control/status bits into the aclk domain.
// Each channel is independent; any_pulse_o is a plain OR of the registered pulses.
module async_input_synchro
  import async_synchro_pkg::*;
#(
  parameter int unsigned          NB_CH         = 8,
  parameter int unsigned          SYNC_STAGES   = 2,
  parameter int unsigned          FILTER_CYCLES = 4,
  parameter logic [NB_CH-1:0]     RESET_VAL     = {NB_CH{1'b0}},
  parameter logic [2*NB_CH-1:0]   MODE          = {NB_CH{MODE_RISE}}
) (
  input  logic             aclk,
  input  logic             arstn,
  input  logic [NB_CH-1:0] async_i,
  output logic [NB_CH-1:0] level_o,
  output logic [NB_CH-1:0] pulse_o,
  output logic             any_pulse_o
);

  if (SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_bad_param
    $error("async_input_synchro: SYNC_STAGES must be >= 2 and FILTER_CYCLES >= 1");
  end

  for (genvar ch = 0; ch < NB_CH; ch++) begin : g_ch
    synchro_filter_ch #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_VAL_BIT (RESET_VAL[ch]),
      .MODE_CH       (sync_mode_t'(MODE[2*ch +: 2]))
    ) u_ch (
      .aclk  (aclk),
      .arstn (arstn),
      .din   (async_i[ch]),
      .level (level_o[ch]),
      .pulse (pulse_o[ch])
    );
  end

  // Driven only by flop outputs, so no decode glitches
  assign any_pulse_o = |pulse_o;

endmodule
